// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared state encoding and lane-geometry helpers for the BRAM read packer
package bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int pk_ratio(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

  function automatic int pk_lane_w(input int in_w, input int out_w);
    int r;
    r = out_w / in_w;
    return (r <= 2) ? 1 : $clog2(r);
  endfunction

endpackage

// File: rtl/bram_word_fifo.sv
// rtl/bram_word_fifo.sv - synchronous word FIFO with full/empty flags and free-entry count
module bram_word_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   free_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign free_o  = (AW+1)'(DEPTH) - cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/bram_rd_packer.sv
// rtl/bram_rd_packer.sv - packs narrow BRAM read beats into words and streams them out with keep/last
module bram_rd_packer
  import bram_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SKID       = 2,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   start_i,
  input  logic [LEN_WIDTH-1:0]                   frame_len_i,
  output logic                                   rd_en_o,
  input  logic                                   rd_valid_i,
  input  logic [IN_WIDTH-1:0]                    rd_data_i,
  output logic [OUT_WIDTH-1:0]                   m_data_o,
  output logic [pk_ratio(IN_WIDTH,OUT_WIDTH)-1:0] m_keep_o,
  output logic                                   m_last_o,
  output logic                                   m_valid_o,
  input  logic                                   m_ready_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   overflow_o
);

  localparam int R  = pk_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int LW = pk_lane_w(IN_WIDTH, OUT_WIDTH);
  localparam int FW = OUT_WIDTH + R + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e               state_q;
  logic [LEN_WIDTH-1:0] len_q, rx_cnt_q, rx_cnt_nx;
  logic [LW-1:0]        lane_q;
  logic [OUT_WIDTH-1:0] shift_q, word_c;
  logic [R-1:0]         keep_q, keep_c;
  logic                 rd_en_q, done_q, ovf_q;

  logic                 beat_ok, is_last, push, pop, ovf_set, fifo_drain;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_free;
  logic [FW-1:0]        fifo_rdata;

  always_comb begin
    word_c = shift_q;
    keep_c = keep_q;
    word_c[int'(lane_q)*IN_WIDTH +: IN_WIDTH] = rd_data_i;
    keep_c[lane_q] = 1'b1;
  end

  // Beats beyond the frame length are discarded without being treated as an error.
  assign beat_ok    = (state_q == ST_RUN) && rd_valid_i && (rx_cnt_q != len_q);
  assign rx_cnt_nx  = rx_cnt_q + 1'b1;
  assign is_last    = (rx_cnt_nx == len_q);
  assign push       = beat_ok && ((lane_q == LW'(R-1)) || is_last);
  assign pop        = !fifo_empty && m_ready_i;
  assign ovf_set    = push && fifo_full && !pop;
  assign fifo_drain = fifo_empty || (pop && (fifo_free == CW'(FIFO_DEPTH-1)));

  bram_word_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .data_i ({is_last, keep_c, word_c}),
    .pop_i  (pop),
    .data_o (fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .free_o (fifo_free)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      rx_cnt_q <= '0;
      lane_q   <= '0;
      shift_q  <= '0;
      keep_q   <= '0;
      rd_en_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ovf_set) ovf_q <= 1'b1;
      if (beat_ok) begin
        rx_cnt_q <= rx_cnt_nx;
        if (push) begin
          lane_q  <= '0;
          shift_q <= '0;
          keep_q  <= '0;
        end else begin
          lane_q  <= lane_q + 1'b1;
          shift_q <= word_c;
          keep_q  <= keep_c;
        end
      end
      case (state_q)
        ST_IDLE: begin
          rd_en_q <= 1'b0;
          if (start_i) begin
            len_q    <= frame_len_i;
            rx_cnt_q <= '0;
            lane_q   <= '0;
            shift_q  <= '0;
            keep_q   <= '0;
            ovf_q    <= 1'b0;
            if (frame_len_i == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (push && is_last) begin
            state_q <= ST_FLUSH;
            rd_en_q <= 1'b0;
          end else begin
            rd_en_q <= (rx_cnt_q < len_q) && (fifo_free > CW'(SKID));
          end
        end
        ST_FLUSH: begin
          rd_en_q <= 1'b0;
          if (fifo_drain) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          rd_en_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_en_o    = rd_en_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign m_valid_o  = !fifo_empty;
  assign m_data_o   = fifo_empty ? '0 : fifo_rdata[OUT_WIDTH-1:0];
  assign m_keep_o   = fifo_empty ? '0 : fifo_rdata[OUT_WIDTH +: R];
  assign m_last_o   = fifo_empty ? 1'b0 : fifo_rdata[FW-1];

endmodule

// File: tb/tb_bram_rd_packer.sv
// tb/tb_bram_rd_packer.sv - scoreboard bench for bram_rd_packer
module tb_bram_rd_packer;

  localparam int D = 8;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] frame_len_i;
  logic        rd_en_o;
  logic        rd_valid_i;
  logic [7:0]  rd_data_i;
  logic [31:0] m_data_o;
  logic [3:0]  m_keep_o;
  logic        m_last_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        overflow_o;

  bram_rd_packer dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .frame_len_i(frame_len_i),
    .rd_en_o    (rd_en_o),
    .rd_valid_i (rd_valid_i),
    .rd_data_i  (rd_data_i),
    .m_data_o   (m_data_o),
    .m_keep_o   (m_keep_o),
    .m_last_o   (m_last_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  exp_t        sbq[$];
  int unsigned last_pop_cyc = 0;
  int          rmode = 0;
  int          force_left = 0;
  logic [7:0]  next_data = 8'h00;
  logic [D-1:0] hist = '0;
  int unsigned t_done;
  int          beats;
  int          n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_frame(input int len);
    start_i = 1'b1;
    frame_len_i = 16'(len);
    tick();
    start_i = 1'b0;
  endtask

  task automatic reader_cfg(input int mode, input logic [7:0] base);
    rmode = 0;
    repeat (D + 2) tick();
    next_data = base;
    rmode = mode;
  endtask

  task automatic wait_done(input string name, input int budget, output int unsigned at);
    int  k;
    bit  seen;
    k = 0;
    seen = 1'b0;
    at = 0;
    while (!seen && k < budget) begin
      @(negedge clk_i);
      k++;
      if (done_o) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    check(name, 64'(seen), 64'd1);
    tick();
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy_o && k < 200) begin
      tick();
      k++;
    end
    check(name, 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst_i = 1'b0;
    start_i = 1'b0;
    frame_len_i = '0;
    m_ready_i = 1'b0;
    rd_valid_i = 1'b0;
    rd_data_i = '0;

    fork
      // reader: either a latency-D echo of rd_en_o, or a forced burst that ignores it
      forever begin
        logic v;
        @(posedge clk_i);
        #1;
        v = 1'b0;
        hist = {hist[D-2:0], rd_en_o};
        if (rmode == 1) v = hist[D-1];
        else if (rmode == 2 && force_left > 0) begin
          v = 1'b1;
          force_left--;
        end
        rd_valid_i = v;
        rd_data_i = v ? next_data : 8'h00;
        if (v) next_data = next_data + 8'h01;
      end
      // monitor: pops the scoreboard on every accepted output word
      forever begin
        exp_t e;
        @(negedge clk_i);
        if (rst_i && m_valid_o && m_ready_i) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got data 0x%0h, expected no word", m_data_o);
          end else begin
            e = sbq.pop_front();
            check("word_data", 64'(m_data_o), 64'(e.d));
            check("word_keep", 64'(m_keep_o), 64'(e.k));
            check("word_last", 64'(m_last_o), 64'(e.l));
            if (m_last_o) last_pop_cyc = cyc;
          end
        end
      end
    join_none

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_outputs", 64'({rd_en_o, m_valid_o, m_data_o, m_keep_o, m_last_o,
                               busy_o, done_o, overflow_o}), 64'd0);
    rst_i = 1'b1;
    tick();

    // basic 8-beat frame
    m_ready_i = 1'b1;
    reader_cfg(1, 8'h01);
    sbq.push_back('{d: 32'h04030201, k: 4'hF, l: 1'b0});
    sbq.push_back('{d: 32'h08070605, k: 4'hF, l: 1'b1});
    start_frame(8);
    check("basic_busy", 64'(busy_o), 64'd1);
    wait_done("basic_done_seen", 200, t_done);
    check("basic_done_latency", 64'(t_done - last_pop_cyc), 64'd1);
    wait_idle("basic_idle");
    check("basic_sb_empty", 64'(sbq.size()), 64'd0);

    // partial tail word
    reader_cfg(1, 8'hA0);
    sbq.push_back('{d: 32'hA3A2A1A0, k: 4'hF, l: 1'b0});
    sbq.push_back('{d: 32'h0000A5A4, k: 4'h3, l: 1'b1});
    start_frame(6);
    wait_done("tail_done_seen", 200, t_done);
    wait_idle("tail_idle");
    check("tail_sb_empty", 64'(sbq.size()), 64'd0);

    // zero-length frame
    reader_cfg(0, 8'h00);
    start_i = 1'b1;
    frame_len_i = 16'd0;
    @(negedge clk_i);
    check("zero_done_n1", 64'(done_o), 64'd0);
    tick();
    start_i = 1'b0;
    @(negedge clk_i);
    check("zero_done_n2", 64'(done_o), 64'd1);
    check("zero_no_valid", 64'(m_valid_o), 64'd0);
    @(negedge clk_i);
    check("zero_done_n3", 64'(done_o), 64'd0);
    check("zero_idle", 64'(busy_o), 64'd0);
    tick();

    // backpressure with a latency-D reader, plus an ignored start during RUN
    m_ready_i = 1'b0;
    reader_cfg(1, 8'h00);
    for (int k = 0; k < 16; k++)
      sbq.push_back('{d: {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, k: 4'hF, l: (k == 15)});
    start_frame(64);
    n = 0;
    while (!rd_en_o && n < 50) begin tick(); n++; end
    while (rd_en_o && n < 100) begin tick(); n++; end
    check("bp_rd_en_drop", 64'(rd_en_o), 64'd0);
    repeat (20) tick();
    check("bp_rd_en_held", 64'(rd_en_o), 64'd0);
    check("bp_no_overflow", 64'(overflow_o), 64'd0);
    check("bp_valid_stalled", 64'(m_valid_o), 64'd1);
    start_frame(4);
    check("bp_start_ignored_busy", 64'(busy_o), 64'd1);
    m_ready_i = 1'b1;
    wait_done("bp_done_seen", 2000, t_done);
    wait_idle("bp_idle");
    check("bp_sb_empty", 64'(sbq.size()), 64'd0);
    check("bp_no_overflow_end", 64'(overflow_o), 64'd0);

    // forced overflow: 24 beats ignoring rd_en_o with the sink stalled
    m_ready_i = 1'b0;
    reader_cfg(2, 8'h10);
    sbq.push_back('{d: 32'h13121110, k: 4'hF, l: 1'b0});
    sbq.push_back('{d: 32'h17161514, k: 4'hF, l: 1'b0});
    sbq.push_back('{d: 32'h1B1A1918, k: 4'hF, l: 1'b0});
    sbq.push_back('{d: 32'h1F1E1D1C, k: 4'hF, l: 1'b0});
    start_frame(24);
    force_left = 24;
    beats = 0;
    n = 0;
    while (beats < 24 && n < 200) begin
      @(negedge clk_i);
      n++;
      if (rd_valid_i) begin
        if (beats == 19) check("ovf_before_word5", 64'(overflow_o), 64'd0);
        if (beats == 20) check("ovf_after_word5", 64'(overflow_o), 64'd1);
        beats++;
      end
    end
    check("ovf_beats_sent", 64'(beats), 64'd24);
    repeat (3) tick();
    check("ovf_sticky", 64'(overflow_o), 64'd1);
    m_ready_i = 1'b1;
    wait_done("ovf_done_seen", 200, t_done);
    wait_idle("ovf_idle");
    check("ovf_sticky_idle", 64'(overflow_o), 64'd1);
    check("ovf_sb_empty", 64'(sbq.size()), 64'd0);

    // reset mid-frame, then a clean 4-beat frame
    reader_cfg(2, 8'h30);
    start_frame(8);
    check("ovf_cleared_by_start", 64'(overflow_o), 64'd0);
    force_left = 3;
    n = 0;
    while (force_left > 0 && n < 20) begin tick(); n++; end
    tick();
    rst_i = 1'b0;
    #1;
    check("midreset_outputs", 64'({rd_en_o, m_valid_o, m_data_o, m_keep_o, m_last_o,
                                  busy_o, done_o, overflow_o}), 64'd0);
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    reader_cfg(2, 8'h50);
    sbq.push_back('{d: 32'h53525150, k: 4'hF, l: 1'b1});
    start_frame(4);
    force_left = 4;
    wait_done("postreset_done_seen", 200, t_done);
    wait_idle("postreset_idle");
    repeat (5) tick();
    check("postreset_sb_empty", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
